seq_trigger_monitor: RTL

Parametrised, multi-lane successor to the single-bit registered trigger subcircuits in the trojan-detection netlist set. Each of CH lanes carries four input bits through a DEPTH-stage stallable pipeline and evaluates the trigger function (a AND NOT x) OR NOT c on the delayed operands. Qualified hits are counted per lane in saturating counters, with a sticky alarm once any lane reaches THRESH. The block sits between the stimulus/capture logic and the detection readout.

---
 rtl/seq_trigger_monitor_if.sv | 27 ++
 rtl/seq_trigger_monitor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/seq_trigger_monitor_if.sv
// Control, operand and readout bundle for seq_trigger_monitor.
// master = stimulus/readout side, slave = the monitor itself.
interface seq_trigger_monitor_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8,
  parameter int SEL_W = (CH > 1) ? $clog2(CH) : 1
);
  logic             en;
  logic             clear;
  logic             in_valid;
  logic [CH-1:0]    a, b, c, x;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic [CH-1:0]    out_hit;
  logic [CNT_W-1:0] count_out;
  logic             alarm;

  modport master (
    output en, clear, in_valid, a, b, c, x, sel,
    input  out_valid, out_hit, count_out, alarm
  );

  modport slave (
    input  en, clear, in_valid, a, b, c, x, sel,
    output out_valid, out_hit, count_out, alarm
  );
endinterface

// File: rtl/seq_trigger_monitor.sv
// Multi-lane registered trigger monitor: stallable operand pipeline, per-lane
// saturating hit counters and a threshold alarm derived from the counters.
module seq_trigger_lane #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             over
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // clear beats a coincident hit and ignores the stall enable
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                       cnt_d = '0;
    else if (inc && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign cnt  = cnt_q;
  assign over = (cnt_q >= THR);
endmodule

module seq_trigger_monitor #(
  parameter int CH     = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic                 I1470,
  input  logic                 I1477,
  seq_trigger_monitor_if.slave bus
);
  typedef struct packed {
    logic [CH-1:0] a;
    logic [CH-1:0] x;
    logic [CH-1:0] c;
    logic [CH-1:0] ab;
  } ops_t;

  ops_t ops_in, ops_last;
  assign ops_in = '{a: bus.a, x: bus.x, c: bus.c, ab: bus.a | bus.b};

  // valid shift register; the top bit is the output stage's valid
  logic [DEPTH-1:0] vld_pipe_d, vld_pipe_q;
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (bus.en) begin
      vld_pipe_d[0] = bus.in_valid;
      for (int k = 1; k < DEPTH; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    end
  end

  // operands travel through DEPTH-1 stages; the output stage keeps only the hit
  generate
    if (DEPTH == 1) begin : g_direct
      assign ops_last = ops_in;
    end else begin : g_pipe
      ops_t [DEPTH-2:0] ops_d, ops_q;
      always_comb begin
        ops_d = ops_q;
        if (bus.en) begin
          ops_d[0] = ops_in;
          for (int k = 1; k < DEPTH-1; k++) ops_d[k] = ops_q[k-1];
        end
      end
      always_ff @(posedge I1470 or posedge I1477)
        if (I1477) ops_q <= '0;
        else       ops_q <= ops_d;
      assign ops_last = ops_q[DEPTH-2];
    end
  endgenerate

  logic [CH-1:0] hit_d, hit_q;
  always_comb begin
    hit_d = hit_q;
    if (bus.en) hit_d = (ops_last.a & ~ops_last.x & ops_last.ab) | ~ops_last.c;
  end

  always_ff @(posedge I1470 or posedge I1477)
    if (I1477) begin
      vld_pipe_q <= '0;
      hit_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      hit_q      <= hit_d;
    end

  logic                     out_vld;
  logic [CH-1:0]            out_hit;
  logic [CH-1:0][CNT_W-1:0] cnt;
  logic [CH-1:0]            over;

  assign out_vld = vld_pipe_q[DEPTH-1];
  assign out_hit = hit_q & {CH{out_vld}};

  // a stalled output sample is seen again next cycle, so en gates the increment
  for (genvar i = 0; i < CH; i++) begin : g_lane
    seq_trigger_lane #(.CNT_W(CNT_W), .THRESH(THRESH)) u_lane (
      .clk  (I1470),
      .rst  (I1477),
      .inc  (bus.en & out_hit[i]),
      .clear(bus.clear),
      .cnt  (cnt[i]),
      .over (over[i])
    );
  end

  logic [CNT_W-1:0] count_mux;
  always_comb begin
    count_mux = '0;
    if (32'(bus.sel) < CH) count_mux = cnt[bus.sel];
  end

  assign bus.out_valid = out_vld;
  assign bus.out_hit   = out_hit;
  assign bus.count_out = count_mux;
  assign bus.alarm     = |over;
endmodule
